// File: rtl/ct_idu_rf_pipe2_launch_ctrl.sv
// ct_idu_rf_pipe2_launch_ctrl
// RF-stage launch controller for pipe2 (branch/jump pipe).
// Holds one BIQ issue in the RF register, launches it to BJU EX1 when the
// operands are ready, EX1 is not stalled and a BJU PC-FIFO credit is free.
// Optional performance counters are enabled by defining CT_IDU_PIPE2_PERF_CNT_EN.
module ct_idu_rf_pipe2_launch_ctrl #(
    parameter int unsigned CREDIT_NUM = 8,
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned IID_W      = 7
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst_b,
    input  logic               rtu_yy_xx_flush,
    input  logic               rtu_idu_flush_fe,
    input  logic               biq_rf_pipe2_issue_vld,
    input  logic [31:0]        biq_rf_pipe2_opcode,
    input  logic [IID_W-1:0]   biq_rf_pipe2_iid,
    output logic               rf_biq_pipe2_issue_rdy,
    input  logic               rf_pipe2_src_no_rdy,
    input  logic               bju_rf_pipe2_stall,
    input  logic               bju_idu_pcfifo_pop,
    output logic [31:0]        rf_pipe2_decd_opcode,
    input  logic [7:0]         pipe2_decd_func,
    input  logic [20:0]        pipe2_decd_offset,
    output logic               idu_bju_ex1_sel,
    output logic [7:0]         idu_bju_ex1_func,
    output logic [20:0]        idu_bju_ex1_offset,
    output logic [IID_W-1:0]   idu_bju_ex1_iid,
    output logic               rf_biq_pipe2_launch_fail,
    output logic [IID_W-1:0]   rf_biq_pipe2_launch_fail_iid
`ifdef CT_IDU_PIPE2_PERF_CNT_EN
    ,
    output logic [15:0]        rf_pipe2_fail_cnt,
    output logic [15:0]        rf_pipe2_credit_stall_cnt
`endif
);

    localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_NUM);

    logic                rf_vld;
    logic [31:0]         rf_opcode;
    logic [IID_W-1:0]    rf_iid;
    logic [CREDIT_W-1:0] credit_cnt;

    logic                rf_vld_nxt;
    logic [31:0]         rf_opcode_nxt;
    logic [IID_W-1:0]    rf_iid_nxt;
    logic [CREDIT_W-1:0] credit_cnt_nxt;

    logic flush;
    logic credit_nz;
    logic launch;
    logic fail;
    logic hold;
    logic issue_rdy;
    logic issue;

    // Launch / fail / hold qualification; flush dominates, then stall, then operands, then credits
    assign flush     = rtu_yy_xx_flush | rtu_idu_flush_fe;
    assign credit_nz = (credit_cnt != '0);
    assign launch    = rf_vld & ~flush & ~bju_rf_pipe2_stall & ~rf_pipe2_src_no_rdy & credit_nz;
    assign fail      = rf_vld & ~flush & ~bju_rf_pipe2_stall & rf_pipe2_src_no_rdy;
    assign hold      = rf_vld & ~flush & ~launch & ~fail;

    // Accept only when the RF slot frees this cycle and a credit remains for the newcomer
    assign issue_rdy = ~flush & (~rf_vld | launch | fail) & (credit_cnt > CREDIT_W'(launch));
    assign issue     = biq_rf_pipe2_issue_vld & issue_rdy;

    // Next-state for the RF entry and the PC-FIFO credit counter
    always_comb begin
        rf_vld_nxt     = hold;
        rf_opcode_nxt  = rf_opcode;
        rf_iid_nxt     = rf_iid;
        credit_cnt_nxt = credit_cnt;

        if (issue) begin
            rf_vld_nxt    = 1'b1;
            rf_opcode_nxt = biq_rf_pipe2_opcode;
            rf_iid_nxt    = biq_rf_pipe2_iid;
        end

        // Full flush empties the PC-FIFO, so all credits come back at once
        if (rtu_yy_xx_flush) begin
            credit_cnt_nxt = CREDIT_FULL;
        end else if (launch && !bju_idu_pcfifo_pop) begin
            credit_cnt_nxt = credit_cnt - CREDIT_W'(1);
        end else if (!launch && bju_idu_pcfifo_pop && (credit_cnt != CREDIT_FULL)) begin
            credit_cnt_nxt = credit_cnt + CREDIT_W'(1);
        end
    end

    // RF-stage state registers
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rf_vld     <= 1'b0;
            rf_opcode  <= '0;
            rf_iid     <= '0;
            credit_cnt <= CREDIT_FULL;
        end else begin
            rf_vld     <= rf_vld_nxt;
            rf_opcode  <= rf_opcode_nxt;
            rf_iid     <= rf_iid_nxt;
            credit_cnt <= credit_cnt_nxt;
        end
    end

    // Launch and fail outputs derive from the RF registers in the same cycle
    assign rf_biq_pipe2_issue_rdy       = issue_rdy;
    assign rf_pipe2_decd_opcode         = rf_opcode;
    assign idu_bju_ex1_sel              = launch;
    assign idu_bju_ex1_func             = launch ? pipe2_decd_func   : 8'h0;
    assign idu_bju_ex1_offset           = launch ? pipe2_decd_offset : 21'h0;
    assign idu_bju_ex1_iid              = launch ? rf_iid            : '0;
    assign rf_biq_pipe2_launch_fail     = fail;
    assign rf_biq_pipe2_launch_fail_iid = fail ? rf_iid : '0;

`ifdef CT_IDU_PIPE2_PERF_CNT_EN
    logic credit_stall;
    assign credit_stall = rf_vld & ~flush & ~bju_rf_pipe2_stall & ~rf_pipe2_src_no_rdy & ~credit_nz;

    // Saturating event counters, cleared by reset only
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rf_pipe2_fail_cnt         <= 16'h0;
            rf_pipe2_credit_stall_cnt <= 16'h0;
        end else begin
            if (fail && (rf_pipe2_fail_cnt != 16'hFFFF)) begin
                rf_pipe2_fail_cnt <= rf_pipe2_fail_cnt + 16'h1;
            end
            if (credit_stall && (rf_pipe2_credit_stall_cnt != 16'hFFFF)) begin
                rf_pipe2_credit_stall_cnt <= rf_pipe2_credit_stall_cnt + 16'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ct_idu_rf_pipe2_launch_ctrl.sv
// Directed self-checking bench for ct_idu_rf_pipe2_launch_ctrl.
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_ct_idu_rf_pipe2_launch_ctrl;

    localparam int unsigned IID_W = 7;

    logic               clk;
    logic               rst_n;
    logic               full_flush;
    logic               fe_flush;
    logic               issue_vld;
    logic [31:0]        opcode;
    logic [IID_W-1:0]   iid;
    logic               issue_rdy;
    logic               src_no_rdy;
    logic               stall;
    logic               pop;
    logic [31:0]        decd_opcode;
    logic [7:0]         decd_func;
    logic [20:0]        decd_offset;
    logic               ex1_sel;
    logic [7:0]         ex1_func;
    logic [20:0]        ex1_offset;
    logic [IID_W-1:0]   ex1_iid;
    logic               lfail;
    logic [IID_W-1:0]   lfail_iid;

    int checks   = 0;
    int failures = 0;

    ct_idu_rf_pipe2_launch_ctrl #(.CREDIT_NUM(8), .CREDIT_W(4), .IID_W(IID_W)) dut (
        .forever_cpuclk               (clk),
        .cpurst_b                     (rst_n),
        .rtu_yy_xx_flush              (full_flush),
        .rtu_idu_flush_fe             (fe_flush),
        .biq_rf_pipe2_issue_vld       (issue_vld),
        .biq_rf_pipe2_opcode          (opcode),
        .biq_rf_pipe2_iid             (iid),
        .rf_biq_pipe2_issue_rdy       (issue_rdy),
        .rf_pipe2_src_no_rdy          (src_no_rdy),
        .bju_rf_pipe2_stall           (stall),
        .bju_idu_pcfifo_pop           (pop),
        .rf_pipe2_decd_opcode         (decd_opcode),
        .pipe2_decd_func              (decd_func),
        .pipe2_decd_offset            (decd_offset),
        .idu_bju_ex1_sel              (ex1_sel),
        .idu_bju_ex1_func             (ex1_func),
        .idu_bju_ex1_offset           (ex1_offset),
        .idu_bju_ex1_iid              (ex1_iid),
        .rf_biq_pipe2_launch_fail     (lfail),
        .rf_biq_pipe2_launch_fail_iid (lfail_iid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_step();
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        full_flush  = 1'b0;
        fe_flush    = 1'b0;
        issue_vld   = 1'b0;
        opcode      = 32'h00208063;
        iid         = '0;
        src_no_rdy  = 1'b0;
        stall       = 1'b0;
        pop         = 1'b0;
        decd_func   = 8'h20;
        decd_offset = 21'h00010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        #1;
        chk("rst_rdy",     32'(issue_rdy),      32'd1);
        chk("rst_sel",     32'(ex1_sel),        32'd0);
        chk("rst_fail",    32'(lfail),          32'd0);
        chk("rst_func",    32'(ex1_func),       32'd0);
        chk("rst_offset",  32'(ex1_offset),     32'd0);
        chk("rst_iid",     32'(ex1_iid),        32'd0);
        chk("rst_opcode",  decd_opcode,         32'd0);
        chk("rst_credit",  32'(dut.credit_cnt), 32'd8);

        // beq issue, launch one cycle later
        next_step();
        issue_vld = 1'b1; iid = 7'd5; #1;
        chk("beq_rdy", 32'(issue_rdy), 32'd1);
        next_step();
        issue_vld = 1'b0; #1;
        chk("beq_sel",    32'(ex1_sel),        32'd1);
        chk("beq_func",   32'(ex1_func),       32'h20);
        chk("beq_offset", 32'(ex1_offset),     32'h10);
        chk("beq_iid",    32'(ex1_iid),        32'd5);
        chk("beq_opcode", decd_opcode,         32'h00208063);
        next_step(); #1;
        chk("beq_credit", 32'(dut.credit_cnt), 32'd7);
        chk("beq_vld",    32'(dut.rf_vld),     32'd0);
        chk("beq_sel0",   32'(ex1_sel),        32'd0);

        // Return the credit, then 8 back-to-back issues with no pop
        next_step();
        pop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            next_step();
            pop = 1'b0;
            issue_vld = (k < 8);
            iid = IID_W'(10 + k);
            #1;
            chk("b2b_sel", 32'(ex1_sel), (k >= 1 && k <= 8) ? 32'd1 : 32'd0);
            if (k >= 1 && k <= 8) chk("b2b_iid", 32'(ex1_iid), 32'(10 + k - 1));
            chk("b2b_rdy", 32'(issue_rdy), (k < 8) ? 32'd1 : 32'd0);
            chk("b2b_credit", 32'(dut.credit_cnt), (k <= 1) ? 32'd8 : 32'(9 - k));
        end

        // 9th issue with no credit is refused until a credit returns
        next_step();
        issue_vld = 1'b1; iid = 7'd30; #1;
        chk("nocr_rdy",    32'(issue_rdy),      32'd0);
        chk("nocr_sel",    32'(ex1_sel),        32'd0);
        chk("nocr_credit", 32'(dut.credit_cnt), 32'd0);
        next_step();
        pop = 1'b1; #1;
        chk("nocr_pop_rdy", 32'(issue_rdy), 32'd0);
        next_step();
        pop = 1'b0; #1;
        chk("nocr_acc_rdy",    32'(issue_rdy),      32'd1);
        chk("nocr_acc_credit", 32'(dut.credit_cnt), 32'd1);
        next_step();
        issue_vld = 1'b0; #1;
        chk("ninth_sel", 32'(ex1_sel),   32'd1);
        chk("ninth_iid", 32'(ex1_iid),   32'd30);
        chk("ninth_rdy", 32'(issue_rdy), 32'd0);
        next_step(); #1;
        chk("ninth_credit", 32'(dut.credit_cnt), 32'd0);

        // Refill to 3 credits
        repeat (3) begin
            next_step();
            pop = 1'b1;
        end
        next_step();
        pop = 1'b0; issue_vld = 1'b1; iid = 7'd40; #1;
        chk("refill_credit", 32'(dut.credit_cnt), 32'd3);
        chk("refill_rdy",    32'(issue_rdy),      32'd1);

        // Operand not ready: launch fail, entry dropped, credits unchanged
        next_step();
        issue_vld = 1'b0; src_no_rdy = 1'b1; #1;
        chk("fail_pulse", 32'(lfail),     32'd1);
        chk("fail_iid",   32'(lfail_iid), 32'd40);
        chk("fail_sel",   32'(ex1_sel),   32'd0);
        next_step();
        src_no_rdy = 1'b0; #1;
        chk("fail_vld",    32'(dut.rf_vld),     32'd0);
        chk("fail_credit", 32'(dut.credit_cnt), 32'd3);
        chk("fail_clr",    32'(lfail),          32'd0);

        // Stall for 3 cycles; stall outranks src_no_rdy
        next_step();
        issue_vld = 1'b1; iid = 7'd41;
        for (int s = 0; s < 3; s++) begin
            next_step();
            issue_vld = 1'b0; stall = 1'b1; src_no_rdy = (s == 1); #1;
            chk("stall_sel",  32'(ex1_sel),   32'd0);
            chk("stall_rdy",  32'(issue_rdy), 32'd0);
            chk("stall_fail", 32'(lfail),     32'd0);
        end
        // Launch on the cycle stall drops, together with a pop
        next_step();
        stall = 1'b0; src_no_rdy = 1'b0; pop = 1'b1; #1;
        chk("unstall_sel",    32'(ex1_sel),        32'd1);
        chk("unstall_iid",    32'(ex1_iid),        32'd41);
        chk("unstall_credit", 32'(dut.credit_cnt), 32'd3);
        next_step();
        pop = 1'b0; #1;
        chk("lpop_credit", 32'(dut.credit_cnt), 32'd3);

        // Front-end flush kills the RF entry, credits untouched
        issue_vld = 1'b1; iid = 7'd42;
        next_step();
        issue_vld = 1'b0; fe_flush = 1'b1; #1;
        chk("fef_sel",  32'(ex1_sel),   32'd0);
        chk("fef_fail", 32'(lfail),     32'd0);
        chk("fef_rdy",  32'(issue_rdy), 32'd0);
        next_step();
        fe_flush = 1'b0; issue_vld = 1'b1; iid = 7'd43; #1;
        chk("fef_vld",    32'(dut.rf_vld),     32'd0);
        chk("fef_credit", 32'(dut.credit_cnt), 32'd3);

        // Invalid func still launches; next issue accepted behind it
        next_step();
        issue_vld = 1'b1; iid = 7'd44; decd_func = 8'h00; #1;
        chk("f0_sel",  32'(ex1_sel),   32'd1);
        chk("f0_func", 32'(ex1_func),  32'd0);
        chk("f0_iid",  32'(ex1_iid),   32'd43);
        chk("f0_rdy",  32'(issue_rdy), 32'd1);

        // Full flush with issue_vld and pop at 2 credits
        next_step();
        decd_func = 8'h20; full_flush = 1'b1; issue_vld = 1'b1; iid = 7'd45; pop = 1'b1; #1;
        chk("ff_pre_credit", 32'(dut.credit_cnt), 32'd2);
        chk("ff_pre_vld",    32'(dut.rf_vld),     32'd1);
        chk("ff_rdy",        32'(issue_rdy),      32'd0);
        chk("ff_sel",        32'(ex1_sel),        32'd0);
        chk("ff_fail",       32'(lfail),          32'd0);
        next_step();
        full_flush = 1'b0; issue_vld = 1'b0; pop = 1'b0; #1;
        chk("ff_vld",    32'(dut.rf_vld),     32'd0);
        chk("ff_credit", 32'(dut.credit_cnt), 32'd8);
        chk("ff_post_sel",  32'(ex1_sel),     32'd0);
        chk("ff_post_fail", 32'(lfail),       32'd0);
        chk("ff_post_rdy",  32'(issue_rdy),   32'd1);

        // Pop at full credit saturates
        next_step();
        pop = 1'b1;
        next_step();
        pop = 1'b0; #1;
        chk("sat_credit", 32'(dut.credit_cnt), 32'd8);

        next_step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
